// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and default operand width for serial_adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_adder_bit.sv
// serial_adder_bit: combinational one-bit full adder (a, b, cin -> s, cout)
module serial_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit per clock LSB first, {carryout,sum} = a+b+carryin
// ports: clk, rst_n (async active-low), start/a/b/carryin in; busy, done pulse, sum, carryout out
// SERIAL_ADDER_OVERFLOW_EN adds the signed overflow output, held with sum
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0] count;
  logic carry, s, co;
  serial_adder_bit u_bit (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .s(s), .cout(co));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      count <= '0;
      carry <= 1'b0;
      sum <= '0;
      carryout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          sum <= {s, sum[WIDTH-1:1]};
          carry <= co;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            carryout <= co;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow <= carry ^ co;
`endif
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
          busy <= start;
          state <= start ? SHIFT : IDLE;
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            carry <= carryin;
            count <= '0;
            sum <= '0;
            carryout <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow <= 1'b0;
`endif
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven scoreboard bench for serial_adder (WIDTH=8)
module tb_serial_adder;
  localparam int WIDTH = 8;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;
  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
    int         cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] a_i = '0;
  logic [7:0] b_i = '0;
  logic cin_i = 1'b0;
  logic busy, done, co;
  logic [7:0] sum;
  logic ov;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int bcnt = 0;
  exp_t q[$];
  vec_t tbl[8];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a_i),
    .b(b_i),
    .carryin(cin_i),
    .busy(busy),
    .done(done),
    .sum(sum),
    .carryout(co)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .overflow(ov)
`endif
  );
`ifndef SERIAL_ADDER_OVERFLOW_EN
  assign ov = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) bcnt = 0;
    else if (busy) bcnt++;
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", sum, e.s);
        chk("carryout", co, e.co);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("overflow", ov, e.ov);
`endif
        chk("latency_cycle", cyc, e.cyc);
        chk("busy_cycles", bcnt, WIDTH);
      end
      bcnt = 0;
    end
  end

  // call at a negedge; start is presented for exactly one edge
  task automatic go(input logic [7:0] a, input logic [7:0] b, input logic cin,
                    input logic [7:0] s, input logic c, input logic o);
    exp_t e;
    a_i = a;
    b_i = b;
    cin_i = cin;
    start = 1'b1;
    e.s = s;
    e.co = c;
    e.ov = o;
    e.cyc = cyc + WIDTH + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  initial begin
    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{8'h40, 8'h3F, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carryout", co, 0);
    chk("rst_overflow", ov, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      go(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, tbl[i].ov);
      wait_done();
      if (i == 0) begin
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("sum_held", sum, tbl[i].s);
      end
    end
    // back-to-back: start held in the DONE cycle
    @(negedge clk);
    go(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    wait_done();
    a_i = 8'h03;
    b_i = 8'h04;
    cin_i = 1'b0;
    go(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);
    chk("b2b_busy", busy, 1);
    wait_done();
    // start during SHIFT is ignored, operand changes have no effect
    @(negedge clk);
    go(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    @(negedge clk);
    a_i = 8'hFF;
    b_i = 8'hFF;
    cin_i = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
    chk("no_extra_busy", busy, 0);
    // reset mid-operation aborts immediately
    go(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_carryout", co, 0);
    chk("abort_overflow", ov, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("no_done_after_abort", done, 0);
    go(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
